// File: rtl/hazard_match_unit.sv
// rtl/hazard_match_unit.sv - pipeline address/control registers and match generation for the hazard unit
// Optional feature macro: HAZ_R15_EXCLUDE_EN (R15 never produces a match)
module hazard_match_unit #(
  parameter int AW = 4,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] InstrF,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          FlushE,
  input  logic [AW-1:0] RA1D,
  input  logic [AW-1:0] RA2D,
  input  logic [AW-1:0] WA3D,
  input  logic          RegWriteD,
  input  logic          MemtoRegD,
  input  logic          PCSrcD,
  input  logic          CondExE,
  output logic [IW-1:0] InstrD,
  output logic          ValidD,
  output logic          Match_1E_M,
  output logic          Match_1E_W,
  output logic          Match_2E_M,
  output logic          Match_2E_W,
  output logic          Match_12D_E,
  output logic          RegWriteM,
  output logic          RegWriteW,
  output logic          MemtoRegE,
  output logic          PCSrcW,
  output logic          PCWrPendingF
);

  localparam logic [AW-1:0] PC_ADDR = AW'(15);

  logic [AW-1:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic          reg_write_e, pc_src_e, pc_src_m;

  // PC reads come from PCPlus8 when the exclusion is enabled, so R15 never forwards
  function automatic logic addr_eq(input logic [AW-1:0] src, input logic [AW-1:0] dst);
`ifdef HAZ_R15_EXCLUDE_EN
    return (src == dst) && (src != PC_ADDR) && (dst != PC_ADDR);
`else
    return (src == dst);
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD <= '0;
      ValidD <= 1'b0;
    end else if (FlushD) begin
      InstrD <= '0;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      InstrD <= InstrF;
      ValidD <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra1_e       <= '0;
      ra2_e       <= '0;
      wa3_e       <= '0;
      reg_write_e <= 1'b0;
      MemtoRegE   <= 1'b0;
      pc_src_e    <= 1'b0;
    end else if (FlushE) begin
      ra1_e       <= '0;
      ra2_e       <= '0;
      wa3_e       <= '0;
      reg_write_e <= 1'b0;
      MemtoRegE   <= 1'b0;
      pc_src_e    <= 1'b0;
    end else begin
      ra1_e       <= RA1D;
      ra2_e       <= RA2D;
      wa3_e       <= WA3D;
      reg_write_e <= RegWriteD;
      MemtoRegE   <= MemtoRegD;
      pc_src_e    <= PCSrcD;
    end
  end

  // Writes that fail their condition are squashed on entry to M
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM <= 1'b0;
      pc_src_m  <= 1'b0;
      wa3_m     <= '0;
      RegWriteW <= 1'b0;
      PCSrcW    <= 1'b0;
      wa3_w     <= '0;
    end else begin
      RegWriteM <= reg_write_e & CondExE;
      pc_src_m  <= pc_src_e & CondExE;
      wa3_m     <= wa3_e;
      RegWriteW <= RegWriteM;
      PCSrcW    <= pc_src_m;
      wa3_w     <= wa3_m;
    end
  end

  always_comb begin
    Match_1E_M   = addr_eq(ra1_e, wa3_m);
    Match_1E_W   = addr_eq(ra1_e, wa3_w);
    Match_2E_M   = addr_eq(ra2_e, wa3_m);
    Match_2E_W   = addr_eq(ra2_e, wa3_w);
    Match_12D_E  = addr_eq(RA1D, wa3_e) | addr_eq(RA2D, wa3_e);
    PCWrPendingF = PCSrcD | pc_src_e | pc_src_m;
  end

endmodule

// File: tb/tb_hazard_match_unit.sv
// tb/tb_hazard_match_unit.sv - directed self-checking bench for hazard_match_unit
module tb_hazard_match_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrF;
  logic        StallD, FlushD, FlushE;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteD, MemtoRegD, PCSrcD, CondExE;
  logic [31:0] InstrD;
  logic        ValidD, Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic        RegWriteM, RegWriteW, MemtoRegE, PCSrcW, PCWrPendingF;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_match_unit #(.AW(4), .IW(32)) dut (
    .clk(clk), .reset(reset), .InstrF(InstrF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .RegWriteD(RegWriteD),
    .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD), .CondExE(CondExE), .InstrD(InstrD),
    .ValidD(ValidD), .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    InstrF = 32'h0; StallD = 0; FlushD = 0; FlushE = 0;
    RA1D = 0; RA2D = 0; WA3D = 0;
    RegWriteD = 0; MemtoRegD = 0; PCSrcD = 0; CondExE = 1;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    RA1D = 3; RA2D = 3;
    #2;
    total++; if (Match_1E_M !== 1'b1) begin bad++; $display("FAIL rst_m1em got=%b want=1", Match_1E_M); end
    total++; if (Match_2E_W !== 1'b1) begin bad++; $display("FAIL rst_m2ew got=%b want=1", Match_2E_W); end
    total++; if (Match_12D_E !== 1'b0) begin bad++; $display("FAIL rst_m12de got=%b want=0", Match_12D_E); end
    total++; if ({RegWriteM, RegWriteW, PCSrcW, ValidD, MemtoRegE} !== 5'b0) begin bad++; $display("FAIL rst_ctrl got=%b want=00000", {RegWriteM, RegWriteW, PCSrcW, ValidD, MemtoRegE}); end
    total++; if (InstrD !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", InstrD); end
    total++; if (PCWrPendingF !== 1'b0) begin bad++; $display("FAIL rst_pend0 got=%b want=0", PCWrPendingF); end
    PCSrcD = 1; #1;
    total++; if (PCWrPendingF !== 1'b1) begin bad++; $display("FAIL rst_pend1 got=%b want=1", PCWrPendingF); end
    RA2D = 0; PCSrcD = 0; #1;
    total++; if (Match_12D_E !== 1'b1) begin bad++; $display("FAIL rst_m12de_zero got=%b want=1", Match_12D_E); end
    @(negedge clk);
    reset = 1;
    idle_inputs();
  endtask

  task automatic test_forward();
    drain();
    WA3D = 5; RegWriteD = 1; CondExE = 1;
    tick();
    WA3D = 0; RegWriteD = 0; RA1D = 5; #1;
    total++; if (Match_12D_E !== 1'b1) begin bad++; $display("FAIL fwd_m12de got=%b want=1", Match_12D_E); end
    tick();
    total++; if (Match_1E_M !== 1'b1) begin bad++; $display("FAIL fwd_m1em got=%b want=1", Match_1E_M); end
    total++; if (RegWriteM !== 1'b1) begin bad++; $display("FAIL fwd_rwm got=%b want=1", RegWriteM); end
    total++; if (Match_2E_M !== 1'b0) begin bad++; $display("FAIL fwd_m2em got=%b want=0", Match_2E_M); end
    tick();
    total++; if (Match_1E_W !== 1'b1) begin bad++; $display("FAIL fwd_m1ew got=%b want=1", Match_1E_W); end
    total++; if (RegWriteW !== 1'b1) begin bad++; $display("FAIL fwd_rww got=%b want=1", RegWriteW); end
    total++; if (Match_1E_M !== 1'b0) begin bad++; $display("FAIL fwd_m1em_gone got=%b want=0", Match_1E_M); end
  endtask

  task automatic test_load_use();
    drain();
    WA3D = 7; MemtoRegD = 1; InstrF = 32'hA5A5_0001;
    tick();
    WA3D = 0; MemtoRegD = 0; RA2D = 7; InstrF = 32'hB6B6_0002; #1;
    total++; if (Match_12D_E !== 1'b1) begin bad++; $display("FAIL lu_m12de got=%b want=1", Match_12D_E); end
    total++; if (MemtoRegE !== 1'b1) begin bad++; $display("FAIL lu_m2re got=%b want=1", MemtoRegE); end
    total++; if (InstrD !== 32'hA5A5_0001) begin bad++; $display("FAIL lu_instr got=%h want=a5a50001", InstrD); end
    StallD = 1; FlushE = 1; RA1D = 7;
    tick();
    total++; if (InstrD !== 32'hA5A5_0001) begin bad++; $display("FAIL lu_hold got=%h want=a5a50001", InstrD); end
    total++; if (ValidD !== 1'b1) begin bad++; $display("FAIL lu_valid got=%b want=1", ValidD); end
    total++; if (MemtoRegE !== 1'b0) begin bad++; $display("FAIL lu_flush_m2r got=%b want=0", MemtoRegE); end
    total++; if (Match_12D_E !== 1'b0) begin bad++; $display("FAIL lu_flush_wa3 got=%b want=0", Match_12D_E); end
    StallD = 0; FlushE = 0;
    tick();
    total++; if (InstrD !== 32'hB6B6_0002) begin bad++; $display("FAIL lu_resume got=%h want=b6b60002", InstrD); end
  endtask

  task automatic test_cond_fail();
    drain();
    RegWriteD = 1; PCSrcD = 1; WA3D = 9; #1;
    total++; if (PCWrPendingF !== 1'b1) begin bad++; $display("FAIL cf_pend_d got=%b want=1", PCWrPendingF); end
    tick();
    RegWriteD = 0; PCSrcD = 0; WA3D = 0; CondExE = 0; #1;
    total++; if (PCWrPendingF !== 1'b1) begin bad++; $display("FAIL cf_pend_e got=%b want=1", PCWrPendingF); end
    tick();
    CondExE = 1; #1;
    total++; if (RegWriteM !== 1'b0) begin bad++; $display("FAIL cf_rwm got=%b want=0", RegWriteM); end
    total++; if (PCWrPendingF !== 1'b0) begin bad++; $display("FAIL cf_pend_m got=%b want=0", PCWrPendingF); end
    tick();
    total++; if (PCSrcW !== 1'b0) begin bad++; $display("FAIL cf_pcsw1 got=%b want=0", PCSrcW); end
    tick();
    total++; if (PCSrcW !== 1'b0) begin bad++; $display("FAIL cf_pcsw2 got=%b want=0", PCSrcW); end
  endtask

  task automatic test_branch();
    drain();
    PCSrcD = 1; CondExE = 1; #1;
    total++; if (PCWrPendingF !== 1'b1) begin bad++; $display("FAIL br_pend1 got=%b want=1", PCWrPendingF); end
    tick();
    PCSrcD = 0; #1;
    total++; if ({PCWrPendingF, PCSrcW} !== 2'b10) begin bad++; $display("FAIL br_pend2 got=%b want=10", {PCWrPendingF, PCSrcW}); end
    tick();
    total++; if ({PCWrPendingF, PCSrcW} !== 2'b10) begin bad++; $display("FAIL br_pend3 got=%b want=10", {PCWrPendingF, PCSrcW}); end
    tick();
    total++; if ({PCWrPendingF, PCSrcW} !== 2'b01) begin bad++; $display("FAIL br_pcsw got=%b want=01", {PCWrPendingF, PCSrcW}); end
    InstrF = 32'h1234_5678;
    tick();
    total++; if (ValidD !== 1'b1) begin bad++; $display("FAIL br_valid_pre got=%b want=1", ValidD); end
    StallD = 1; FlushD = 1;
    tick();
    total++; if ({ValidD, InstrD} !== 33'h0) begin bad++; $display("FAIL br_flushd got=%b/%h want=0/0", ValidD, InstrD); end
    StallD = 0; FlushD = 0;
  endtask

  task automatic test_async_reset();
    drain();
    InstrF = 32'hCAFE_0003;
    tick();
    WA3D = 2; RegWriteD = 1;
    tick();
    tick();
    #2 reset = 0; #1;
    total++; if ({ValidD, RegWriteM} !== 2'b00) begin bad++; $display("FAIL ar_clear got=%b want=00", {ValidD, RegWriteM}); end
    @(negedge clk);
    reset = 1;
    idle_inputs();
    InstrF = 32'hCAFE_0004;
    tick();
    total++; if (InstrD !== 32'hCAFE_0004 || ValidD !== 1'b1) begin bad++; $display("FAIL ar_first got=%h/%b want=cafe0004/1", InstrD, ValidD); end
  endtask

  task automatic test_r15();
    logic exp;
`ifdef HAZ_R15_EXCLUDE_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    drain();
    RA1D = 15; WA3D = 15; RegWriteD = 1;
    tick();
    WA3D = 0; RegWriteD = 0; #1;
    total++; if (Match_12D_E !== exp) begin bad++; $display("FAIL r15_m12de got=%b want=%b", Match_12D_E, exp); end
    tick();
    total++; if (Match_1E_M !== exp) begin bad++; $display("FAIL r15_m1em got=%b want=%b", Match_1E_M, exp); end
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_cond_fail();
    test_branch();
    test_async_reset();
    test_r15();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
